// File: rtl/stream_mux_pkg.sv
// Shared types and constants for the two-input round-robin stream mux.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
// Contents: src_id_t source index type, SRC_RESET_PRIO reset value of the
//           round-robin priority register.
package stream_mux_pkg;

   // Index of a source stream: 0 = in0, 1 = in1.
   typedef logic src_id_t;

   // Priority register reset value: prio names the last winner, so a reset
   // value of 1 makes in0 win the first contention.
   localparam src_id_t SRC_RESET_PRIO = 1'b1;

endpackage : stream_mux_pkg

// File: rtl/mux.sv
// 1-bit two-way combinational multiplexer primitive.
// Latency: combinational, 0 cycles.
// Backpressure: none (pure datapath).
// Ports: d0, d1 data inputs; sel chooses d1 when high; y selected output.
module mux (
   input  logic d0,
   input  logic d1,
   input  logic sel,
   output logic y
);

   assign y = sel ? d1 : d0;

endmodule : mux

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter with optional packet lock.
// Latency: grant is combinational from requests and state; state updates on accept.
// Backpressure: the caller qualifies grants with its own slot/handshake logic.
// Ports: req0/req1 requests; accept strobe (a granted beat was taken);
//        accept_last (end-of-packet of that beat, STREAM_MUX_RR_LOCK_EN only);
//        grant_valid/grant_idx current grant.
// Macro: STREAM_MUX_RR_LOCK_EN enables packet lock (grant sticks to the
//        source of an unfinished packet).
module rr_arbiter2
   import stream_mux_pkg::*;
(
   input  logic    clk,
   input  logic    rst_n,
   input  logic    req0,
   input  logic    req1,
   input  logic    accept,
`ifdef STREAM_MUX_RR_LOCK_EN
   input  logic    accept_last,
`endif
   output logic    grant_valid,
   output src_id_t grant_idx
);

   src_id_t prio_q;
   src_id_t prio_d;

`ifdef STREAM_MUX_RR_LOCK_EN
   logic    lock_q;
   logic    lock_d;
   src_id_t lock_src_q;
   src_id_t lock_src_d;
`endif

   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = 1'b0;
      if (req0 && req1) begin
         // Contention: prio holds the last winner, so the other side wins.
         grant_valid = 1'b1;
         grant_idx   = ~prio_q;
      end else if (req0) begin
         grant_valid = 1'b1;
         grant_idx   = 1'b0;
      end else if (req1) begin
         grant_valid = 1'b1;
         grant_idx   = 1'b1;
      end
`ifdef STREAM_MUX_RR_LOCK_EN
      // Mid-packet the grant is pinned to the packet owner even when it is
      // idle; the other source waits rather than interleaving beats.
      if (lock_q) begin
         grant_valid = 1'b1;
         grant_idx   = lock_src_q;
      end
`endif
   end

   always_comb begin
      prio_d = prio_q;
      if (accept) begin
         prio_d = grant_idx;
      end
   end

`ifdef STREAM_MUX_RR_LOCK_EN
   always_comb begin
      lock_d     = lock_q;
      lock_src_d = lock_src_q;
      if (accept) begin
         lock_d     = !accept_last;
         lock_src_d = grant_idx;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio_q     <= SRC_RESET_PRIO;
`ifdef STREAM_MUX_RR_LOCK_EN
         lock_q     <= 1'b0;
         lock_src_q <= 1'b0;
`endif
      end else begin
         prio_q     <= prio_d;
`ifdef STREAM_MUX_RR_LOCK_EN
         lock_q     <= lock_d;
         lock_src_q <= lock_src_d;
`endif
      end
   end

endmodule : rr_arbiter2

// File: rtl/stream_mux_rr.sv
// Two-input round-robin valid/ready stream mux with a registered output slot.
// Latency: 1 cycle from input handshake to out_*; 1 beat/cycle with out_ready high.
// Backpressure: readies drop while the slot is full and out_ready is low; drain and reload in one cycle.
// Ports: in0_*/in1_* source streams (valid, data, ready, last*);
//        out_valid/out_data/out_sel/out_last* registered merged stream, out_ready from downstream.
//        (*) last ports exist only with STREAM_MUX_RR_LOCK_EN (packet lock).
module stream_mux_rr
   import stream_mux_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in0_valid,
   input  logic [WIDTH-1:0] in0_data,
   output logic             in0_ready,
   input  logic             in1_valid,
   input  logic [WIDTH-1:0] in1_data,
   output logic             in1_ready,
`ifdef STREAM_MUX_RR_LOCK_EN
   input  logic             in0_last,
   input  logic             in1_last,
   output logic             out_last,
`endif
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_sel,
   input  logic             out_ready
);

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q,  out_data_d;
   src_id_t          out_sel_q,   out_sel_d;
`ifdef STREAM_MUX_RR_LOCK_EN
   logic             out_last_q,  out_last_d;
   logic             grant_last;
`endif

   logic             slot_free;
   logic             grant_valid;
   src_id_t          grant_idx;
   logic             accept;
   logic [WIDTH-1:0] mux_data;

   rr_arbiter2 u_arb (
      .clk         (clk),
      .rst_n       (rst_n),
      .req0        (in0_valid),
      .req1        (in1_valid),
      .accept      (accept),
`ifdef STREAM_MUX_RR_LOCK_EN
      .accept_last (grant_last),
`endif
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   // Per-bit steering of the granted source into the output register.
   for (genvar i = 0; i < WIDTH; i++) begin : g_mux
      mux u_mux (
         .d0  (in0_data[i]),
         .d1  (in1_data[i]),
         .sel (grant_idx),
         .y   (mux_data[i])
      );
   end

`ifdef STREAM_MUX_RR_LOCK_EN
   assign grant_last = grant_idx ? in1_last : in0_last;
`endif

   assign slot_free = !out_valid_q || out_ready;

   // rst_n gates the readies so nothing is offered as accepted during reset.
   assign in0_ready = rst_n && slot_free && grant_valid && (grant_idx == 1'b0);
   assign in1_ready = rst_n && slot_free && grant_valid && (grant_idx == 1'b1);

   // A lock may hold ready high on an idle source; only valid&&ready counts.
   assign accept = (in0_ready && in0_valid) || (in1_ready && in1_valid);

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
`ifdef STREAM_MUX_RR_LOCK_EN
      out_last_d  = out_last_q;
`endif
      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
      // Accept overrides the drain so a simultaneous drain+load keeps valid high.
      if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = mux_data;
         out_sel_d   = grant_idx;
`ifdef STREAM_MUX_RR_LOCK_EN
         out_last_d  = grant_last;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= 1'b0;
`ifdef STREAM_MUX_RR_LOCK_EN
         out_last_q  <= 1'b0;
`endif
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
`ifdef STREAM_MUX_RR_LOCK_EN
         out_last_q  <= out_last_d;
`endif
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;
`ifdef STREAM_MUX_RR_LOCK_EN
   assign out_last  = out_last_q;
`endif

endmodule : stream_mux_rr

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: vector table plus reset and lock sequences.
// Latency: each table row drives inputs at negedge and checks just after it.
// Backpressure: out_ready is driven per row to exercise stalls.
module tb_stream_mux_rr;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in0_valid, in1_valid, out_ready;
   logic [7:0] in0_data, in1_data;
   logic       in0_ready, in1_ready;
   logic       out_valid, out_sel;
   logic [7:0] out_data;
`ifdef STREAM_MUX_RR_LOCK_EN
   logic       in0_last, in1_last, out_last;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   stream_mux_rr #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in0_valid (in0_valid),
      .in0_data  (in0_data),
      .in0_ready (in0_ready),
      .in1_valid (in1_valid),
      .in1_data  (in1_data),
      .in1_ready (in1_ready),
`ifdef STREAM_MUX_RR_LOCK_EN
      .in0_last  (in0_last),
      .in1_last  (in1_last),
      .out_last  (out_last),
`endif
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_ready (out_ready)
   );

   typedef struct {
      logic       i0v;
      logic [7:0] i0d;
      logic       i1v;
      logic [7:0] i1d;
      logic       ordy;
      logic       e_ov;
      logic [7:0] e_od;
      logic       e_os;
      logic       e_r0;
      logic       e_r1;
   } vec_t;

   vec_t tbl[18];

   function automatic vec_t mk(logic i0v, logic [7:0] i0d, logic i1v, logic [7:0] i1d,
                               logic ordy, logic e_ov, logic [7:0] e_od, logic e_os,
                               logic e_r0, logic e_r1);
      vec_t v;
      v.i0v = i0v; v.i0d = i0d; v.i1v = i1v; v.i1d = i1d; v.ordy = ordy;
      v.e_ov = e_ov; v.e_od = e_od; v.e_os = e_os; v.e_r0 = e_r0; v.e_r1 = e_r1;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic i0v, input logic [7:0] i0d, input logic i1v,
                        input logic [7:0] i1d, input logic ordy);
      in0_valid = i0v; in0_data = i0d;
      in1_valid = i1v; in1_data = i1d;
      out_ready = ordy;
   endtask

   initial begin
      // Expected columns: out_valid/out_data/out_sel show the state before
      // this row's clock edge; readies reflect this row's inputs.
      //             i0v i0d    i1v i1d    rdy  ov  od     os  r0  r1
      // Alternation under contention, in0 first after reset.
      tbl[0]  = mk(1, 8'hA0, 1, 8'hB0, 1,   0, 8'h00, 0,  1,  0);
      tbl[1]  = mk(1, 8'hA0, 1, 8'hB0, 1,   1, 8'hA0, 0,  0,  1);
      tbl[2]  = mk(1, 8'hA0, 1, 8'hB0, 1,   1, 8'hB0, 1,  1,  0);
      tbl[3]  = mk(1, 8'hA0, 1, 8'hB0, 1,   1, 8'hA0, 0,  0,  1);
      // in1 alone, back-to-back beats.
      tbl[4]  = mk(0, 8'h00, 1, 8'h01, 1,   1, 8'hB0, 1,  0,  1);
      tbl[5]  = mk(0, 8'h00, 1, 8'h02, 1,   1, 8'h01, 1,  0,  1);
      tbl[6]  = mk(0, 8'h00, 1, 8'h03, 1,   1, 8'h02, 1,  0,  1);
      tbl[7]  = mk(0, 8'h00, 1, 8'h04, 1,   1, 8'h03, 1,  0,  1);
      tbl[8]  = mk(0, 8'h00, 0, 8'h00, 1,   1, 8'h04, 1,  0,  0);
      // Drained slot keeps its data.
      tbl[9]  = mk(0, 8'h00, 0, 8'h00, 0,   0, 8'h04, 1,  0,  0);
      // Fill empty slot, then stall for three cycles.
      tbl[10] = mk(1, 8'hC1, 1, 8'hD1, 0,   0, 8'h04, 1,  1,  0);
      tbl[11] = mk(1, 8'hC1, 1, 8'hD1, 0,   1, 8'hC1, 0,  0,  0);
      tbl[12] = mk(1, 8'hC1, 1, 8'hD1, 0,   1, 8'hC1, 0,  0,  0);
      tbl[13] = mk(1, 8'hC1, 1, 8'hD1, 0,   1, 8'hC1, 0,  0,  0);
      // Resume: drain + reload same cycle, no bubble.
      tbl[14] = mk(1, 8'hC1, 1, 8'hD1, 1,   1, 8'hC1, 0,  0,  1);
      tbl[15] = mk(1, 8'hC1, 0, 8'h00, 1,   1, 8'hD1, 1,  1,  0);
      tbl[16] = mk(0, 8'h00, 0, 8'h00, 1,   1, 8'hC1, 0,  0,  0);
      tbl[17] = mk(0, 8'h00, 0, 8'h00, 0,   0, 8'hC1, 0,  0,  0);

      drive(0, 8'h00, 0, 8'h00, 0);
`ifdef STREAM_MUX_RR_LOCK_EN
      in0_last = 1'b1;
      in1_last = 1'b1;
`endif
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         drive(tbl[i].i0v, tbl[i].i0d, tbl[i].i1v, tbl[i].i1d, tbl[i].ordy);
         #1;
         chk($sformatf("row%0d out_valid", i), {31'b0, out_valid}, {31'b0, tbl[i].e_ov});
         chk($sformatf("row%0d out_data", i),  {24'b0, out_data},  {24'b0, tbl[i].e_od});
         chk($sformatf("row%0d out_sel", i),   {31'b0, out_sel},   {31'b0, tbl[i].e_os});
         chk($sformatf("row%0d in0_ready", i), {31'b0, in0_ready}, {31'b0, tbl[i].e_r0});
         chk($sformatf("row%0d in1_ready", i), {31'b0, in1_ready}, {31'b0, tbl[i].e_r1});
      end

      // Asynchronous reset mid-transfer. Load an in0 beat first so prio
      // points at in0; reset must restore in0-first priority.
      @(negedge clk);
      drive(1, 8'h5A, 0, 8'h00, 0);
      @(posedge clk);
      #2;
      chk("pre_rst out_valid", {31'b0, out_valid}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst out_data", {24'b0, out_data}, 32'h00);
      chk("rst in0_ready", {31'b0, in0_ready}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1, 8'h77, 1, 8'h88, 1);
      #1;
      chk("post_rst in0_ready", {31'b0, in0_ready}, 32'd1);
      chk("post_rst in1_ready", {31'b0, in1_ready}, 32'd0);
      @(posedge clk);
      #1;
      chk("post_rst out_valid", {31'b0, out_valid}, 32'd1);
      chk("post_rst out_data", {24'b0, out_data}, 32'h77);
      chk("post_rst out_sel", {31'b0, out_sel}, 32'd0);

`ifdef STREAM_MUX_RR_LOCK_EN
      // Packet lock: in0 sends E1,E2,(idle,idle),E3(last); in1 holds F1.
      @(negedge clk);
      drive(0, 8'h00, 0, 8'h00, 1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      drive(1, 8'hE1, 1, 8'hF1, 1); in0_last = 1'b0; in1_last = 1'b1;
      #1;
      chk("lk1 in0_ready", {31'b0, in0_ready}, 32'd1);
      chk("lk1 in1_ready", {31'b0, in1_ready}, 32'd0);
      @(negedge clk);
      drive(1, 8'hE2, 1, 8'hF1, 1); in0_last = 1'b0;
      #1;
      chk("lk2 out_data", {24'b0, out_data}, 32'hE1);
      chk("lk2 out_last", {31'b0, out_last}, 32'd0);
      chk("lk2 in1_ready", {31'b0, in1_ready}, 32'd0);
      @(negedge clk);
      drive(0, 8'h00, 1, 8'hF1, 1);
      #1;
      chk("lk3 out_data", {24'b0, out_data}, 32'hE2);
      chk("lk3 in1_ready", {31'b0, in1_ready}, 32'd0);
      @(negedge clk);
      #1;
      chk("lk4 out_valid", {31'b0, out_valid}, 32'd0);
      chk("lk4 in1_ready", {31'b0, in1_ready}, 32'd0);
      @(negedge clk);
      drive(1, 8'hE3, 1, 8'hF1, 1); in0_last = 1'b1;
      #1;
      chk("lk5 out_valid", {31'b0, out_valid}, 32'd0);
      chk("lk5 in1_ready", {31'b0, in1_ready}, 32'd0);
      chk("lk5 in0_ready", {31'b0, in0_ready}, 32'd1);
      @(negedge clk);
      drive(0, 8'h00, 1, 8'hF1, 1);
      #1;
      chk("lk6 out_data", {24'b0, out_data}, 32'hE3);
      chk("lk6 out_sel", {31'b0, out_sel}, 32'd0);
      chk("lk6 out_last", {31'b0, out_last}, 32'd1);
      chk("lk6 in1_ready", {31'b0, in1_ready}, 32'd1);
      @(negedge clk);
      drive(0, 8'h00, 0, 8'h00, 0);
      #1;
      chk("lk7 out_data", {24'b0, out_data}, 32'hF1);
      chk("lk7 out_sel", {31'b0, out_sel}, 32'd1);
      chk("lk7 out_valid", {31'b0, out_valid}, 32'd1);
`endif

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_stream_mux_rr

// File: doc/stream_mux_rr.md
# stream_mux_rr

Two-input round-robin stream multiplexer with valid/ready handshakes and a registered output slot. It is the sequential stage directly upstream of the combinational `mux` primitives: it decides the select each cycle, steers the chosen beat through per-bit `mux` instances, and registers the result. Downstream logic consumes one merged stream plus the source ID of every beat.

## Interface
- `WIDTH`, default 8: data width of each input and of the output.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in0_valid`, `in1_valid`  in  1  source beat present.
- `in0_data`, `in1_data`  in  WIDTH  source payload.
- `in0_ready`, `in1_ready`  out  1  beat accepted this cycle when high together with valid.
- `out_valid`  out  1  output slot holds a beat.
- `out_data`  out  WIDTH  registered payload.
- `out_sel`  out  1  source of the held beat: 0 = in0, 1 = in1.
- `out_ready`  in  1  downstream accepts the held beat.
- `in0_last`, `in1_last`  in  1  end of packet. Present only with `STREAM_MUX_RR_LOCK_EN`.
- `out_last`  out  1  registered end-of-packet flag. Present only with `STREAM_MUX_RR_LOCK_EN`.

## Operation
- Slot free: `slot_free = !out_valid || out_ready`.
- Grant is combinational from the valids and the `prio` register.
  - Only one input valid: that input wins.
  - Both inputs valid: the input opposite `prio` wins.
  - Neither valid: no grant.
- `inN_ready = slot_free && grant==N`.
  - The ready of a non-granted input is always 0.
  - A ready may be high while its valid is low. The handshake only occurs when both are high.
- On a handshake:
  - `out_data`, `out_sel` and `out_last` load from the granted input.
  - `out_valid` becomes 1.
  - `prio` becomes the granted index.
- Slot drains with no new handshake (`out_valid && out_ready`): `out_valid` becomes 0. `out_data` holds its value.
- Output stall (`out_valid && !out_ready`): the slot holds. Both readies are 0. `prio` is unchanged.
- Simultaneous drain and accept in the same cycle: the slot reloads and `out_valid` stays 1. There is no bubble.
- Inputs must hold their valid and data until their handshake. The block does not check this.

## Timing
- Latency: a beat handshaken in cycle t appears on `out_*` in cycle t+1.
- Throughput: 1 beat per cycle while `out_ready` is held high.
- Fairness: with both inputs continuously valid and `out_ready` high, grants alternate 0,1,0,1…
- Combinational paths: `out_ready` → `inN_ready`, and `inN_valid` → `inN_ready`. There is no path from any input to `out_*`.
- Reset values:
  - `out_valid`=0, `out_data`=0, `out_sel`=0, `out_last`=0.
  - `prio`=1, so in0 wins the first contention.
  - `lock`=0.
- Reset asserted mid-transfer: the slot empties immediately and asynchronously. Any held beat is discarded. Readies drop to 0 while `rst_n` is low.

## Configuration
- Macro: `STREAM_MUX_RR_LOCK_EN`.
- Defined (packet lock):
  - Accepting a beat with `last`=0 sets `lock`=1 and records `lock_src` = granted index.
  - While `lock`=1, grant is forced to `lock_src`, even when the other input is valid and the locked input is not. The other input waits.
  - Accepting a beat with `last`=1 clears `lock`. `prio` updates as usual.
  - Single-beat packets (`last`=1 on the first beat) never lock.
- Undefined:
  - Arbitration is per beat.
  - The `last` ports, `lock`, and `lock_src` do not exist.

## Structure
- Package `stream_mux_pkg`:
  - `typedef logic src_id_t` for the source index.
  - `localparam src_id_t SRC_RESET_PRIO = 1'b1`.
- Sub-module `rr_arbiter2`:
  - Holds the grant logic, the `prio` register, and the lock logic.
  - Outputs `grant_valid` and `grant_idx`.
  - Takes `accept` and `accept_last` as update strobes.
- Datapath: a generate loop of `WIDTH` instances of the existing 1-bit `mux` (d0 = `in0_data[i]`, d1 = `in1_data[i]`, sel = `grant_idx`) feeding the output register.
- Top level: the ready, handshake and slot logic.

## Test plan
- After reset, both valid, `in0_data`=8'hA0, `in1_data`=8'hB0, `out_ready`=1 → cycle 1 outputs A0/sel 0, cycle 2 outputs B0/sel 1. Alternation continues.
- Only in1 valid for 4 beats (01..04), `out_ready`=1 → 01..04 out back-to-back with `out_sel`=1 and `in0_ready`=0 throughout.
- Slot full, `out_ready`=0 for 3 cycles, both inputs valid → both readies 0. `out_data` stable. Resuming `out_ready` delivers the held beat, then the next granted beat with no bubble.
- `rst_n` pulled low asynchronously while `out_valid`=1 → `out_valid`=0 within the same cycle. The first grant after release goes to in0.
- LOCK_EN: in0 sends a 3-beat packet (last on beat 3) while in1 is valid continuously → out sequence in0,in0,in0,in1. `in1_ready`=0 during the packet.
- LOCK_EN: lock held with in0 idle for 2 cycles → no output beats. in1 waits until in0 delivers its last beat.
